rgb565_byte_tx: RTL and testbench
=================================

Name: rgb565_byte_tx

Overview:
Transmit-side endpoint for the processed RGB565 pixel stream leaving the image pipeline. The upstream stream (pixel, valid, start-of-frame) has no backpressure. The block absorbs it in a small FIFO and serializes each pixel into two bytes (high, then low) over a valid/ready byte link toward the display/UART/bridge side. It tracks line and frame position and tags bytes with start-of-frame, end-of-line and end-of-frame markers.

Parameters:
FIFO_DEPTH, 16, pixel FIFO entries; power of two, at least 4
H_ACTIVE, 640, pixels per line
V_ACTIVE, 480, lines per frame

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
pixel_in  in  16  RGB565 pixel from processing pipeline
data_valid_in  in  1  pixel_in valid this cycle; no backpressure
sof_in  in  1  qualifies pixel_in as first pixel of a frame; ignored when data_valid_in=0
tx_data  out  8  output byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts byte when tx_valid&tx_ready
tx_sof  out  1  current byte is high byte of frame pixel (0,0)
tx_eol  out  1  current byte is low byte of last pixel of a line
tx_eof  out  1  current byte is low byte of last pixel of the frame
overflow  out  1  sticky: at least one input pixel dropped
clr_overflow  in  1  synchronous clear of overflow
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): tx_data=0, tx_valid=0, tx_sof/eol/eof=0, overflow=0, fifo_level=0, x=y=0, FSM=IDLE, FIFO empty. Reset mid-transfer discards the holding register and all FIFO contents. No partial byte is completed.
- FIFO entry is 17 bits: {sof_in, pixel_in}.
- Write rule: a write is accepted when data_valid_in=1 and either level<FIFO_DEPTH or a pop occurs in the same cycle.
- Drop rule: if data_valid_in=1, level=FIFO_DEPTH and there is no same-cycle pop, the pixel is dropped and overflow is set.
- Overflow priority: if set and clear coincide, set wins.
- fifo_level: registered. Push-only gives +1, pop-only gives -1, push and pop together leave it unchanged.
- Holding register: a pop moves the FIFO head into a 17-bit holding register. Total buffering is FIFO_DEPTH+1 pixels.
- FSM IDLE: if level>0, pop and go to HI. Otherwise tx_valid=0.
- FSM HI: tx_valid=1, tx_data=hold[15:8]. On tx_ready, go to LO.
- FSM LO: tx_valid=1, tx_data=hold[7:0]. On tx_ready, update position. Then, if level>0, pop and go to HI with no bubble cycle. Otherwise go to IDLE.
- Handshake: while tx_valid=1 and tx_ready=0, tx_data and the tag outputs hold stable. tx_valid never drops without an accept.
- Latency: a pixel presented at edge N into an empty, idle block gives tx_valid=1 with its high byte after edge N+1. With tx_ready held at 1, one pixel takes 2 cycles, for a sustained 0.5 pixel/cycle. Sustained input above this rate overflows.
- Position for the held pixel, (px,py):
  - If hold[16]=1, then px=py=0 (resync), regardless of the running counters.
  - Otherwise px,py are the running x,y.
- Tags, registered with tx_data:
  - tx_sof=1 in HI when px=0, py=0.
  - tx_eol=1 in LO when px=H_ACTIVE-1.
  - tx_eof=1 in LO when px=H_ACTIVE-1 and py=V_ACTIVE-1.
- Position update on LO accept:
  - x=px+1; if px=H_ACTIVE-1, then x=0 and y=py+1.
  - If also py=V_ACTIVE-1, then y=0 (frame wraparound).
- sof_in mid-line: the pixel carrying it restarts at (0,0). The remainder of the previous line and frame gets no eol/eof tag.

Test Plan:
- Single pixel: reset, tx_ready=1, one pixel 0xABCD with sof_in=1. Required: tx_data 0xAB with tx_sof=1 on the cycle after the write edge, then 0xCD; then tx_valid=0 and fifo_level=0.
- Backpressure: same pixel with tx_ready=0 for 5 cycles, then 1. Required: tx_data=0xAB and tx_valid=1 held all 5 cycles; then 0xAB accepted, then 0xCD; no extra bytes.
- Overflow, FIFO_DEPTH=16: tx_ready=0, 18 consecutive pixels 0x0001..0x0012. Required: 17 retained (hold plus 16 in the FIFO), pixel 0x0012 dropped, overflow=1, fifo_level=16. Then release tx_ready: bytes 00 01 … 00 11 in order. Pulse clr_overflow: overflow=0.
- Framing, H_ACTIVE=4, V_ACTIVE=2, tx_ready=1: 9 pixels with sof_in on pixel 1 only. Required: tx_sof on bytes 1 and 17, tx_eol on bytes 8 and 16, tx_eof on byte 16 only.
- Resync, H_ACTIVE=4: sof_in asserted on the 3rd pixel of a line. Required: that pixel's high byte carries tx_sof=1; the next tx_eol falls 4 pixels later, not 2.
- Reset mid-operation: 5 pixels queued and FSM in LO with tx_ready=0; assert rst_n=0 for 1 cycle. Required: tx_valid=0, fifo_level=0, overflow=0 immediately. After release, no stale bytes are emitted.

Source files
------------

// File: rtl/rgb565_byte_tx_if.sv
// rtl/rgb565_byte_tx_if.sv - byte link from rgb565_byte_tx toward the display/bridge side
// Carries the serialized byte, its valid/ready handshake and the framing tags.
interface rgb565_byte_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_sof;
   logic       tx_eol;
   logic       tx_eof;

   modport master (
      output tx_data,
      output tx_valid,
      output tx_sof,
      output tx_eol,
      output tx_eof,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  tx_sof,
      input  tx_eol,
      input  tx_eof,
      output tx_ready
   );
endinterface

// File: rtl/rgb565_byte_tx.sv
// rtl/rgb565_byte_tx.sv - RGB565 pixel FIFO and high/low byte serializer with frame tags
// Absorbs a no-backpressure pixel stream and emits two tagged bytes per pixel on a valid/ready link.
module rgb565_byte_tx #(
   parameter int FIFO_DEPTH = 16,
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [15:0]                 pixel_in,
   input  logic                        data_valid_in,
   input  logic                        sof_in,
   rgb565_byte_tx_if.master            tx,
   output logic                        overflow,
   input  logic                        clr_overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
   localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST     = YW'(V_ACTIVE - 1);

   typedef enum logic [1:0] {
      IDLE,
      HI,
      LO
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [16:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic [16:0]   head;
   logic          push;
   logic          pop;
   logic          drop;

   logic [16:0]   hold;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [XW-1:0] x_nxt;
   logic [YW-1:0] y_nxt;
   logic [XW-1:0] px;
   logic [YW-1:0] py;
   logic          last_x;
   logic          last_y;

   logic [7:0]    data_q;
   logic          valid_q;
   logic          sof_q;
   logic          eol_q;
   logic          eof_q;
   logic [7:0]    data_nxt;
   logic          valid_nxt;
   logic          sof_nxt;
   logic          eol_nxt;
   logic          eof_nxt;

   assign head = mem[rd_ptr];
   assign push = data_valid_in && ((level != LEVEL_FULL) || pop);
   assign drop = data_valid_in && (level == LEVEL_FULL) && !pop;

   // A held pixel carrying sof restarts the frame at (0,0) whatever the counters say.
   assign px     = hold[16] ? '0 : x;
   assign py     = hold[16] ? '0 : y;
   assign last_x = (px == X_LAST);
   assign last_y = (py == Y_LAST);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {sof_in, pixel_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      x_nxt     = x;
      y_nxt     = y;
      data_nxt  = data_q;
      valid_nxt = valid_q;
      sof_nxt   = sof_q;
      eol_nxt   = eol_q;
      eof_nxt   = eof_q;

      case (state)
         IDLE: begin
            if (level != '0) begin
               pop = 1'b1;
            end
         end
         HI: begin
            if (tx.tx_ready) begin
               state_nxt = LO;
               data_nxt  = hold[7:0];
               sof_nxt   = 1'b0;
               eol_nxt   = last_x;
               eof_nxt   = last_x && last_y;
            end
         end
         LO: begin
            if (tx.tx_ready) begin
               x_nxt = last_x ? '0 : px + XW'(1);
               y_nxt = last_x ? (last_y ? '0 : py + YW'(1)) : py;
               if (level != '0) begin
                  pop = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  valid_nxt = 1'b0;
                  data_nxt  = '0;
                  sof_nxt   = 1'b0;
                  eol_nxt   = 1'b0;
                  eof_nxt   = 1'b0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // The popped pixel's position is the already-advanced counter unless it resyncs.
      if (pop) begin
         state_nxt = HI;
         valid_nxt = 1'b1;
         data_nxt  = head[15:8];
         sof_nxt   = head[16] || ((x_nxt == '0) && (y_nxt == '0));
         eol_nxt   = 1'b0;
         eof_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         hold    <= '0;
         x       <= '0;
         y       <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         eof_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         x       <= x_nxt;
         y       <= y_nxt;
         data_q  <= data_nxt;
         valid_q <= valid_nxt;
         sof_q   <= sof_nxt;
         eol_q   <= eol_nxt;
         eof_q   <= eof_nxt;
         if (pop) begin
            hold <= head;
         end
      end
   end

   assign tx.tx_data  = data_q;
   assign tx.tx_valid = valid_q;
   assign tx.tx_sof   = sof_q;
   assign tx.tx_eol   = eol_q;
   assign tx.tx_eof   = eof_q;
   assign fifo_level  = level;
endmodule

// File: tb/tb_rgb565_byte_tx.sv
// tb/tb_rgb565_byte_tx.sv - bench for rgb565_byte_tx
// Pixel-queue reference model checked every cycle, plus directed literal scenarios.
module tb_rgb565_byte_tx;
   localparam int D = 16;
   localparam int H = 4;
   localparam int V = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pixel_in = '0;
   logic        data_valid_in = 1'b0;
   logic        sof_in = 1'b0;
   logic        clr_overflow = 1'b0;
   logic        overflow;
   logic [4:0]  fifo_level;

   int n_cmp = 0;
   int n_fail = 0;
   bit started = 1'b0;

   rgb565_byte_tx_if tif ();

   rgb565_byte_tx #(
      .FIFO_DEPTH (D),
      .H_ACTIVE   (H),
      .V_ACTIVE   (V)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pixel_in      (pixel_in),
      .data_valid_in (data_valid_in),
      .sof_in        (sof_in),
      .tx            (tif),
      .overflow      (overflow),
      .clr_overflow  (clr_overflow),
      .fifo_level    (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: queue of buffered pixels, one pixel in flight, running x/y.
   logic [16:0] mq [$];
   logic [16:0] cur;
   bit          busy;
   bit          phase;
   int          mx;
   int          my;
   bit          mov;

   function automatic int cur_px();
      return cur[16] ? 0 : mx;
   endfunction

   function automatic int cur_py();
      return cur[16] ? 0 : my;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         cur = '0;
         busy = 1'b0;
         phase = 1'b0;
         mx = 0;
         my = 0;
         mov = 1'b0;
      end else begin
         int  n;
         bit  accepted;
         bit  finish;
         bit  take;
         bit  do_push;
         int  px;
         int  py;
         n = mq.size();
         accepted = busy && tif.tx_ready;
         finish = accepted && phase;
         take = (!busy || finish) && (n > 0);
         if (finish) begin
            px = cur_px();
            py = cur_py();
            if (px == H - 1) begin
               mx = 0;
               my = (py == V - 1) ? 0 : py + 1;
            end else begin
               mx = px + 1;
               my = py;
            end
         end
         do_push = data_valid_in && ((n < D) || take);
         if (data_valid_in && !do_push) mov = 1'b1;
         else if (clr_overflow) mov = 1'b0;
         if (take) begin
            cur = mq.pop_front();
            busy = 1'b1;
            phase = 1'b0;
         end else if (finish) begin
            busy = 1'b0;
         end else if (accepted) begin
            phase = 1'b1;
         end
         if (do_push) mq.push_back({sof_in, pixel_in});
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("valid", 32'(tif.tx_valid), 32'(busy));
         check("level", 32'(fifo_level), mq.size());
         check("overflow", 32'(overflow), 32'(mov));
         if (busy && tif.tx_valid) begin
            check("data", 32'(tif.tx_data), 32'(phase ? cur[7:0] : cur[15:8]));
            check("sof", 32'(tif.tx_sof), 32'(!phase && cur_px() == 0 && cur_py() == 0));
            check("eol", 32'(tif.tx_eol), 32'(phase && cur_px() == H - 1));
            check("eof", 32'(tif.tx_eof), 32'(phase && cur_px() == H - 1 && cur_py() == V - 1));
         end
      end
   end

   logic [10:0] cap [$];
   always @(negedge clk) begin
      if (rst_n && tif.tx_valid && tif.tx_ready) begin
         cap.push_back({tif.tx_eof, tif.tx_eol, tif.tx_sof, tif.tx_data});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      data_valid_in = 1'b0;
      sof_in = 1'b0;
      clr_overflow = 1'b0;
      tif.tx_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      started = 1'b1;
      cap.delete();
   endtask

   task automatic send(input logic [15:0] p, input logic s);
      data_valid_in = 1'b1;
      pixel_in = p;
      sof_in = s;
      step();
      data_valid_in = 1'b0;
      sof_in = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 300; k++) begin
         if (!tif.tx_valid && fifo_level == 0) break;
         step();
      end
      check("idle_timeout", k, (k < 300) ? k : 0);
   endtask

   initial begin
      tif.tx_ready = 1'b0;
      do_reset();
      check("rst_valid", 32'(tif.tx_valid), 0);
      check("rst_data", 32'(tif.tx_data), 0);
      check("rst_level", 32'(fifo_level), 0);
      check("rst_overflow", 32'(overflow), 0);

      // single pixel
      tif.tx_ready = 1'b1;
      send(16'hABCD, 1'b1);
      check("single_lat_valid", 32'(tif.tx_valid), 0);
      check("single_lat_level", 32'(fifo_level), 1);
      step();
      check("single_hi", {tif.tx_valid, tif.tx_sof, tif.tx_data}, {1'b1, 1'b1, 8'hAB});
      step();
      check("single_lo", {tif.tx_valid, tif.tx_sof, tif.tx_data}, {1'b1, 1'b0, 8'hCD});
      step();
      check("single_end", {tif.tx_valid, 3'b0, fifo_level}, 0);

      // backpressure
      do_reset();
      send(16'hABCD, 1'b1);
      step();
      for (int i = 0; i < 5; i++) begin
         check("bp_hold", {tif.tx_valid, tif.tx_data}, {1'b1, 8'hAB});
         step();
      end
      tif.tx_ready = 1'b1;
      wait_idle();
      repeat (3) step();
      check("bp_count", cap.size(), 2);
      if (cap.size() == 2) begin
         check("bp_b0", 32'(cap[0][7:0]), 32'hAB);
         check("bp_b1", 32'(cap[1][7:0]), 32'hCD);
      end

      // overflow
      do_reset();
      for (int i = 1; i <= 18; i++) begin
         data_valid_in = 1'b1;
         pixel_in = 16'(i);
         step();
      end
      data_valid_in = 1'b0;
      check("ovf_flag", 32'(overflow), 1);
      check("ovf_level", 32'(fifo_level), 16);
      tif.tx_ready = 1'b1;
      wait_idle();
      check("ovf_count", cap.size(), 34);
      if (cap.size() == 34) begin
         int bad;
         bad = 0;
         for (int i = 0; i < 17; i++) begin
            if (cap[2*i][7:0] != 8'h00 || cap[2*i+1][7:0] != 8'(i + 1)) bad++;
         end
         check("ovf_order_bad", bad, 0);
      end
      check("ovf_sticky", 32'(overflow), 1);
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      check("ovf_clear", 32'(overflow), 0);

      // framing: 4x2, 9 pixels, sof on the first only
      do_reset();
      tif.tx_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         data_valid_in = 1'b1;
         pixel_in = 16'($urandom);
         sof_in = (i == 0);
         step();
      end
      data_valid_in = 1'b0;
      sof_in = 1'b0;
      wait_idle();
      check("frame_count", cap.size(), 18);
      if (cap.size() == 18) begin
         for (int k = 0; k < 18; k++) begin
            logic [2:0] e;
            e = 3'b000;
            if (k == 0 || k == 16) e[0] = 1'b1;
            if (k == 7 || k == 15) e[1] = 1'b1;
            if (k == 15) e[2] = 1'b1;
            check("frame_tags", 32'(cap[k][10:8]), 32'(e));
         end
      end

      // resync on the 3rd pixel of a line
      do_reset();
      tif.tx_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         data_valid_in = 1'b1;
         pixel_in = 16'($urandom);
         sof_in = (i == 0 || i == 2);
         step();
      end
      data_valid_in = 1'b0;
      sof_in = 1'b0;
      wait_idle();
      check("resync_count", cap.size(), 14);
      if (cap.size() == 14) begin
         for (int k = 0; k < 14; k++) begin
            logic [2:0] e;
            e = 3'b000;
            if (k == 0 || k == 4) e[0] = 1'b1;
            if (k == 11) e[1] = 1'b1;
            check("resync_tags", 32'(cap[k][10:8]), 32'(e));
         end
      end

      // reset while in LO with 5 pixels queued
      do_reset();
      for (int i = 0; i < 6; i++) begin
         data_valid_in = 1'b1;
         pixel_in = 16'h1200 + 16'(i);
         step();
      end
      data_valid_in = 1'b0;
      tif.tx_ready = 1'b1;
      step();
      tif.tx_ready = 1'b0;
      check("midrst_pre", {tif.tx_valid, 3'b0, fifo_level, tif.tx_data}, {1'b1, 3'b0, 5'd5, 8'h00});
      rst_n = 1'b0;
      #1;
      check("midrst_now", {tif.tx_valid, fifo_level, overflow}, 0);
      step();
      rst_n = 1'b1;
      cap.delete();
      tif.tx_ready = 1'b1;
      repeat (10) step();
      check("midrst_stale", cap.size(), 0);

      // randomized traffic with alternating input rates
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         int rate;
         rate = ((c / 500) % 2 == 1) ? 70 : 30;
         data_valid_in = ($urandom_range(0, 99) < rate);
         pixel_in = 16'($urandom);
         sof_in = ($urandom_range(0, 39) == 0);
         tif.tx_ready = ($urandom_range(0, 99) < 75);
         clr_overflow = ($urandom_range(0, 49) == 0);
         step();
      end
      data_valid_in = 1'b0;
      sof_in = 1'b0;
      clr_overflow = 1'b0;
      tif.tx_ready = 1'b1;
      wait_idle();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
